// File: rtl/vga_pkg.sv
// Shared VGA definitions: default frame geometry, clear colour and the
// sequencer state encoding.
package vga_pkg;

    localparam int unsigned VGA_H_PIX   = 160;
    localparam int unsigned VGA_V_PIX   = 120;
    localparam int unsigned VGA_COLOR_W = 12;

    localparam logic [VGA_COLOR_W-1:0] VGA_BG_COLOR = 12'h000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        WAIT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/draw_sequencer_raster_scan.sv
// Raster x/y counter pair for the frame clear: holds the coordinate currently
// on the pixel bus and presents the following one.
module raster_scan
    import vga_pkg::*;
#(
    parameter int unsigned H_PIX = VGA_H_PIX,
    parameter int unsigned V_PIX = VGA_V_PIX,
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           advance,
    output logic [X_W-1:0] next_x_c,
    output logic [Y_W-1:0] next_y_c,
    output logic           last_c
);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           x_end;

    always_comb begin
        x_end    = (x == X_W'(H_PIX - 1));
        last_c   = x_end && (y == Y_W'(V_PIX - 1));
        next_x_c = x_end ? '0 : x + X_W'(1);
        next_y_c = x_end ? y + Y_W'(1) : y;
    end

    // Start re-arms at the origin; stepping stops on the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= '0;
            y <= '0;
        end else if (advance && !last_c) begin
            x <= next_x_c;
            y <= next_y_c;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level draw sequencer: clears the frame buffer once per frame period,
// then grants each enabled drawing source the pixel-write bus in channel order.
module draw_sequencer
    import vga_pkg::*;
#(
    parameter int unsigned H_PIX        = VGA_H_PIX,
    parameter int unsigned V_PIX        = VGA_V_PIX,
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 8,
    parameter int unsigned COLOR_W      = VGA_COLOR_W,
    parameter int unsigned N_CH         = 2,
    parameter int unsigned FRAME_CYCLES = 500000,
    parameter int unsigned CH_TIMEOUT   = 4096,
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(VGA_BG_COLOR)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         src_valid,
    input  logic [N_CH*X_W-1:0]     src_x,
    input  logic [N_CH*Y_W-1:0]     src_y,
    input  logic [N_CH*COLOR_W-1:0] src_color,
    input  logic [N_CH-1:0]         src_done,
    output logic [N_CH-1:0]         grant,
    output logic                    pix_valid,
    output logic [X_W-1:0]          pix_x,
    output logic [Y_W-1:0]          pix_y,
    output logic [COLOR_W-1:0]      pix_color,
    output logic                    busy,
    output logic                    overrun
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned TO_W = (CH_TIMEOUT > 1) ? $clog2(CH_TIMEOUT) : 1;

    seq_state_e state_q, state_d;

    logic [FC_W-1:0]    fcnt;
    logic               frame_tick;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [N_CH-1:0]    en_q, en_d;
    logic               pending_q, pending_d;
    logic [N_CH-1:0]    grant_d;
    logic               pix_valid_d;
    logic [X_W-1:0]     pix_x_d;
    logic [Y_W-1:0]     pix_y_d;
    logic [COLOR_W-1:0] pix_color_d;
    logic               busy_d;
    logic               overrun_d;

    logic               scan_start, scan_advance, scan_last;
    logic [X_W-1:0]     scan_next_x;
    logic [Y_W-1:0]     scan_next_y;

    logic               begin_frame, end_ch;
    logic [CH_W:0]      sel;

    // Lowest enabled channel at or above index 'from'; MSB flags a hit.
    function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] en, input int from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (en[i] && (i >= from)) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    assign frame_tick = (fcnt == FC_W'(FRAME_CYCLES - 1));

    raster_scan #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .start    (scan_start),
        .advance  (scan_advance),
        .next_x_c (scan_next_x),
        .next_y_c (scan_next_y),
        .last_c   (scan_last)
    );

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        ch_d         = ch_q;
        en_d         = en_q;
        pending_d    = pending_q;
        overrun_d    = overrun;
        grant_d      = '0;
        pix_valid_d  = 1'b0;
        pix_x_d      = '0;
        pix_y_d      = '0;
        pix_color_d  = '0;
        scan_start   = 1'b0;
        scan_advance = 1'b0;
        begin_frame  = 1'b0;
        end_ch       = 1'b0;
        sel          = '0;

        // A period boundary mid-frame is remembered so the next frame starts late, not never.
        if (frame_tick && (state_q == CLEAR || state_q == DRAW)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick && !hold) begin_frame = 1'b1;
            end
            CLEAR: begin
                if (!scan_last) begin
                    scan_advance = 1'b1;
                    pix_valid_d  = 1'b1;
                    pix_x_d      = scan_next_x;
                    pix_y_d      = scan_next_y;
                    pix_color_d  = BG_COLOR;
                end else begin
                    sel    = pick(en_q, 0);
                    end_ch = 1'b1;
                end
            end
            DRAW: begin
                if (src_valid[ch_q]) begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = src_x[ch_q*X_W +: X_W];
                    pix_y_d     = src_y[ch_q*Y_W +: Y_W];
                    pix_color_d = src_color[ch_q*COLOR_W +: COLOR_W];
                end
                if (src_done[ch_q] || (tcnt_q == TO_W'(CH_TIMEOUT - 1))) begin
                    sel    = pick(en_q, int'(ch_q) + 1);
                    end_ch = 1'b1;
                end else begin
                    tcnt_d        = tcnt_q + TO_W'(1);
                    grant_d[ch_q] = 1'b1;
                end
            end
            WAIT: begin
                if (frame_tick || pending_q) begin
                    pending_d = 1'b0;
                    if (!hold) begin_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hand the bus to the next enabled channel with no idle cycle between grants.
        if (end_ch) begin
            if (sel[CH_W]) begin
                state_d       = DRAW;
                ch_d          = sel[CH_W-1:0];
                tcnt_d        = '0;
                grant_d[ch_d] = 1'b1;
            end else begin
                state_d = WAIT;
            end
        end

        if (begin_frame) begin
            state_d     = CLEAR;
            scan_start  = 1'b1;
            en_d        = ch_en;
            pending_d   = 1'b0;
            pix_valid_d = 1'b1;
            pix_x_d     = '0;
            pix_y_d     = '0;
            pix_color_d = BG_COLOR;
        end

        busy_d = (state_d == CLEAR) || (state_d == DRAW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fcnt      <= '0;
            tcnt_q    <= '0;
            ch_q      <= '0;
            en_q      <= '0;
            pending_q <= 1'b0;
            grant     <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt      <= frame_tick ? '0 : fcnt + FC_W'(1);
            tcnt_q    <= tcnt_d;
            ch_q      <= ch_d;
            en_q      <= en_d;
            pending_q <= pending_d;
            grant     <= grant_d;
            pix_valid <= pix_valid_d;
            pix_x     <= pix_x_d;
            pix_y     <= pix_y_d;
            pix_color <= pix_color_d;
            busy      <= busy_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: expected pixels (with their arrival
// cycle) are queued by the stimulus and checked by an independent monitor.
module tb_draw_sequencer;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int NC  = 3;
    localparam int FC  = 32;
    localparam int TO  = 8;
    localparam int XW  = 8;
    localparam int YW  = 8;
    localparam int CW  = 12;
    localparam int BG  = 'h123;
    localparam int T0  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [NC-1:0]     ch_en;
    logic [NC-1:0]     src_valid;
    logic [NC*XW-1:0]  src_x;
    logic [NC*YW-1:0]  src_y;
    logic [NC*CW-1:0]  src_color;
    logic [NC-1:0]     src_done;
    logic [NC-1:0]     grant;
    logic              pix_valid;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic [CW-1:0]     pix_color;
    logic              busy;
    logic              overrun;

    typedef struct {
        int x;
        int y;
        int color;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    draw_sequencer #(
        .H_PIX        (H),
        .V_PIX        (V),
        .X_W          (XW),
        .Y_W          (YW),
        .COLOR_W      (CW),
        .N_CH         (NC),
        .FRAME_CYCLES (FC),
        .CH_TIMEOUT   (TO),
        .BG_COLOR     (CW'(BG))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .ch_en     (ch_en),
        .src_valid (src_valid),
        .src_x     (src_x),
        .src_y     (src_y),
        .src_color (src_color),
        .src_done  (src_done),
        .grant     (grant),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid pixel must match the head of the queue, including its cycle.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel cyc=%0d got (%0d,%0d,%h)", cyc, pix_x, pix_y, pix_color);
            end else begin
                mon_e = q.pop_front();
                if (int'(pix_x) != mon_e.x || int'(pix_y) != mon_e.y ||
                    int'(pix_color) != mon_e.color || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL pixel got (%0d,%0d,%h)@%0d expected (%0d,%0d,%h)@%0d",
                             pix_x, pix_y, pix_color, cyc, mon_e.x, mon_e.y, mon_e.color, mon_e.cyc);
                end
            end
        end else if (pix_valid === 1'b0) begin
            checks++;
            if (pix_x != '0 || pix_y != '0 || pix_color != '0) begin
                errors++;
                $display("FAIL idle_bus cyc=%0d got (%0d,%0d,%h) expected zeros", cyc, pix_x, pix_y, pix_color);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int x, input int y, input int c, input int t);
        exp_t e;
        e.x = x; e.y = y; e.color = c; e.cyc = t;
        q.push_back(e);
    endtask

    task automatic push_clear(input int t);
        for (int i = 0; i < H*V; i++) push(i % H, i / H, BG, t + i);
    endtask

    task automatic set_src(input int ch, input logic v, input int x, input int y,
                           input int c, input logic d);
        src_valid[ch]           = v;
        src_x[ch*XW +: XW]      = XW'(x);
        src_y[ch*YW +: YW]      = YW'(y);
        src_color[ch*CW +: CW]  = CW'(c);
        src_done[ch]            = d;
    endtask

    task automatic clear_src();
        src_valid = '0;
        src_x     = '0;
        src_y     = '0;
        src_color = '0;
        src_done  = '0;
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        ch_en = '0;
        clear_src();

        goto(2);
        chk("reset_grant", int'(grant), 0);
        chk("reset_pix_valid", int'(pix_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overrun", int'(overrun), 0);
        goto(T0);
        rst = 1'b0;

        // Frame 1: clear only, no channels enabled.
        push_clear(T0 + 32);
        goto(T0 + 43);  chk("f1_busy_clear", int'(busy), 1);
        goto(T0 + 44);  chk("f1_busy_wait", int'(busy), 0);
                        chk("f1_grant_wait", int'(grant), 0);

        // Frame 2: ch0 then ch2, ch1 skipped, foreign strobes ignored.
        goto(T0 + 50);  ch_en = 3'b101; push_clear(T0 + 64);
        goto(T0 + 75);  chk("f2_grant_pre", int'(grant), 0);
        goto(T0 + 76);  chk("f2_grant_ch0_a", int'(grant), 1);
                        set_src(0, 1'b1, 10, 20, 'hABC, 1'b0);
                        set_src(1, 1'b1, 1, 1, 'h111, 1'b0);
                        src_done[2] = 1'b1;
                        push(10, 20, 'hABC, T0 + 77);
        goto(T0 + 77);  chk("f2_grant_ch0_b", int'(grant), 1);
                        clear_src();
                        set_src(0, 1'b1, 11, 21, 'hDEF, 1'b1);
                        push(11, 21, 'hDEF, T0 + 78);
        goto(T0 + 78);  chk("f2_grant_ch2_a", int'(grant), 4);
                        clear_src();
                        set_src(0, 1'b1, 3, 3, 'h333, 1'b0);
                        src_done[1] = 1'b1;
        goto(T0 + 79);  chk("f2_grant_ch2_b", int'(grant), 4);
                        clear_src();
                        set_src(2, 1'b1, 200, 100, 'h5A5, 1'b1);
                        push(200, 100, 'h5A5, T0 + 80);
        goto(T0 + 80);  clear_src();
                        chk("f2_grant_done", int'(grant), 0);
                        chk("f2_busy_done", int'(busy), 0);

        // Frame 3: ch1 never finishes, timeout releases after 8 cycles.
        goto(T0 + 85);  ch_en = 3'b010; push_clear(T0 + 96);
        goto(T0 + 100); ch_en = 3'b111;
        goto(T0 + 107); chk("f3_grant_pre", int'(grant), 0);
                        chk("f3_busy_clear", int'(busy), 1);
        goto(T0 + 108); chk("f3_grant_first", int'(grant), 2);
                        set_src(1, 1'b1, 7, 8, 'h0F0, 1'b0);
                        src_done[0] = 1'b1;
                        push(7, 8, 'h0F0, T0 + 109);
        goto(T0 + 109); clear_src();
        goto(T0 + 115); chk("f3_grant_last", int'(grant), 2);
        goto(T0 + 116); chk("f3_grant_released", int'(grant), 0);
                        chk("f3_busy_done", int'(busy), 0);

        // Frame 4: all three channels time out, spilling past the period boundary.
        push_clear(T0 + 128);
        goto(T0 + 147); chk("f4_grant_ch0", int'(grant), 1);
        goto(T0 + 148); chk("f4_grant_ch1", int'(grant), 2);
        goto(T0 + 150); ch_en = 3'b000;
        goto(T0 + 156); chk("f4_grant_ch2", int'(grant), 4);
        goto(T0 + 159); chk("f4_overrun_before", int'(overrun), 0);
        goto(T0 + 160); chk("f4_overrun_set", int'(overrun), 1);
        goto(T0 + 163); chk("f4_grant_ch2_last", int'(grant), 4);
                        push_clear(T0 + 165);
        goto(T0 + 164); chk("f4_grant_off", int'(grant), 0);
                        chk("f4_busy_wait", int'(busy), 0);
        goto(T0 + 165); chk("f5_busy_restart", int'(busy), 1);
        goto(T0 + 177); chk("f5_busy_wait", int'(busy), 0);
                        chk("f5_grant_none", int'(grant), 0);

        // Held frame: no activity across the tick, then a normal frame.
        goto(T0 + 185); hold = 1'b1;
        goto(T0 + 193); chk("hold_busy", int'(busy), 0);
        goto(T0 + 200); hold = 1'b0; ch_en = 3'b001; push_clear(T0 + 224);

        // Reset in the middle of a grant.
        goto(T0 + 236); chk("f7_grant_ch0", int'(grant), 1);
                        chk("f7_overrun_sticky", int'(overrun), 1);
        goto(T0 + 238); rst = 1'b1;
        goto(T0 + 239); chk("rst_grant", int'(grant), 0);
                        chk("rst_pix_valid", int'(pix_valid), 0);
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_overrun", int'(overrun), 0);
        goto(T0 + 242); rst = 1'b0;
        goto(T0 + 250); chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
